pulse_handshake_tx: RTL and testbench

//   Source-side transmitter for the handshaked toggle pulse-CDC channel. It

---
 rtl/pulse_handshake_tx.sv | 87 ++++++++
 tb/tb_pulse_handshake_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pulse_handshake_tx.sv
// Source side of the handshaked toggle pulse-CDC channel: queues clkA event
// pulses and launches them one at a time as toggles acknowledged by the far side.
module pulse_handshake_tx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clkA,
  input  logic             rstB,
  input  logic             pulse_i,
  input  logic             ack_tgl_i,
  output logic             req_tgl_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             drop_o,
  output logic             overflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_q, req_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic                   drop_q, drop_d;
  logic                   overflow_q, overflow_d;

  logic ack_s, aligned, empty, full, want, launch, bypass, full_drop, inc, dec;

  always_comb begin
    ack_s     = sync_q[SYNC_STAGES-1];
    aligned   = (ack_s == req_q);
    empty     = (pending_q == '0);
    full      = (pending_q == CNT_MAX);
    want      = !empty || pulse_i;
    launch    = want && aligned;
    // Queued events go first; a fresh pulse only bypasses an empty queue.
    bypass    = launch && empty;
    full_drop = pulse_i && full && !launch;
    inc       = pulse_i && !bypass && !full_drop;
    dec       = launch && !empty;
  end

  // Next-state and registered-output computation.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], ack_tgl_i};
    req_d      = req_q;
    state_d    = state_q;
    pending_d  = pending_q + CNT_W'(inc) - CNT_W'(dec);
    drop_d     = full_drop;
    overflow_d = overflow_q || full_drop;

    if (launch) begin
      req_d   = !req_q;
      state_d = WAIT_ACK;
    end else if (aligned) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clkA) begin
    if (rstB) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      req_q      <= 1'b0;
      pending_q  <= '0;
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      req_q      <= req_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  assign req_tgl_o  = req_q;
  assign pending_o  = pending_q;
  assign drop_o     = drop_q;
  assign overflow_o = overflow_q;
  // Busy covers both an outstanding launch and a far side that has not caught up.
  assign busy_o     = (state_q == WAIT_ACK) || !aligned;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Directed bench for pulse_handshake_tx: a default instance with a 3-cycle
// loopback receiver model and a CNT_W=2 instance for queue overflow.
module tb_pulse_handshake_tx;

  logic       clkA = 1'b0;
  logic       rstB;
  logic       pulse_i, ack_tgl_i, req_tgl_o, busy_o, drop_o, overflow_o;
  logic [3:0] pending_o;

  logic       pulse2, ack2, req2, busy2, drop2, ovf2;
  logic [1:0] pend2;

  logic       ack_manual, ack_val, lb_hold;
  logic [2:0] lb;
  logic       req_prev = 1'b0;
  int         tog = 0;
  int         ncmp = 0;
  int         nerr = 0;
  int         base;

  always #5 clkA = ~clkA;

  pulse_handshake_tx dut (
    .clkA(clkA), .rstB(rstB), .pulse_i(pulse_i), .ack_tgl_i(ack_tgl_i),
    .req_tgl_o(req_tgl_o), .busy_o(busy_o), .pending_o(pending_o),
    .drop_o(drop_o), .overflow_o(overflow_o)
  );

  pulse_handshake_tx #(.SYNC_STAGES(2), .CNT_W(2)) dut_ov (
    .clkA(clkA), .rstB(rstB), .pulse_i(pulse2), .ack_tgl_i(ack2),
    .req_tgl_o(req2), .busy_o(busy2), .pending_o(pend2),
    .drop_o(drop2), .overflow_o(ovf2)
  );

  // Far receiver model: returns req as ack three clkA edges later.
  always @(posedge clkA) begin
    if (rstB) lb <= 3'b000;
    else if (!lb_hold) lb <= {lb[1:0], req_tgl_o};
  end
  assign ack_tgl_i = ack_manual ? ack_val : lb[2];

  always @(negedge clkA) begin
    if (req_tgl_o !== req_prev) tog <= tog + 1;
    req_prev <= req_tgl_o;
  end

  task automatic tick();
    @(negedge clkA);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((pending_o != 4'd0 || busy_o) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    rstB = 1'b1; pulse_i = 1'b0; pulse2 = 1'b0; ack2 = 1'b0;
    ack_manual = 1'b1; ack_val = 1'b0; lb_hold = 1'b0;

    // Reset
    repeat (3) tick();
    chk("rst_req",  32'(req_tgl_o),  32'd0);
    chk("rst_busy", 32'(busy_o),     32'd0);
    chk("rst_pend", 32'(pending_o),  32'd0);
    chk("rst_drop", 32'(drop_o),     32'd0);
    chk("rst_ovf",  32'(overflow_o), 32'd0);
    rstB = 1'b0; ack_manual = 1'b0;
    repeat (2) tick();

    // Single event through the loopback
    base = tog;
    pulse_i = 1'b1; tick(); pulse_i = 1'b0;
    chk("single_req_e1",  32'(req_tgl_o), 32'd1);
    chk("single_busy_e1", 32'(busy_o),    32'd1);
    for (int k = 2; k <= 7; k++) begin
      tick();
      chk($sformatf("single_busy_e%0d", k), 32'(busy_o), 32'(k < 7));
    end
    repeat (2) tick();
    chk("single_toggles", 32'(tog - base), 32'd1);
    chk("single_pend",    32'(pending_o),  32'd0);

    // Burst with ack held, then released
    base = tog; lb_hold = 1'b1;
    pulse_i = 1'b1; repeat (5) tick(); pulse_i = 1'b0;
    chk("burst_pend",  32'(pending_o), 32'd4);
    chk("burst_req",   32'(req_tgl_o), 32'd0);
    chk("burst_busy",  32'(busy_o),    32'd1);
    repeat (2) tick();
    chk("burst_launches_held", 32'(tog - base), 32'd1);
    lb_hold = 1'b0;
    wait_idle("burst_drain_timeout", 200);
    chk("burst_toggles", 32'(tog - base), 32'd5);
    chk("burst_pend0",   32'(pending_o),  32'd0);
    chk("burst_req_end", 32'(req_tgl_o),  32'd0);
    chk("burst_ovf",     32'(overflow_o), 32'd0);

    // Overflow on the CNT_W=2 instance, ack held low
    pulse2 = 1'b1; repeat (4) tick();
    chk("ovf_pend_full", 32'(pend2), 32'd3);
    chk("ovf_drop_pre",  32'(drop2), 32'd0);
    chk("ovf_flag_pre",  32'(ovf2),  32'd0);
    tick(); pulse2 = 1'b0;
    chk("ovf_drop",      32'(drop2), 32'd1);
    chk("ovf_flag",      32'(ovf2),  32'd1);
    chk("ovf_pend_hold", 32'(pend2), 32'd3);
    tick();
    chk("ovf_drop_1cyc", 32'(drop2), 32'd0);
    chk("ovf_sticky",    32'(ovf2),  32'd1);
    chk("ovf_req",       32'(req2),  32'd1);

    // Pulse on the cycle the ack realigns: immediate relaunch
    base = tog;
    pulse_i = 1'b1; tick(); pulse_i = 1'b0;
    chk("simul_req_e1", 32'(req_tgl_o), 32'd1);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk($sformatf("simul_busy_e%0d", k), 32'(busy_o), 32'd1);
    end
    pulse_i = 1'b1; tick(); pulse_i = 1'b0;
    chk("simul_relaunch", 32'(req_tgl_o), 32'd0);
    chk("simul_busy_e7",  32'(busy_o),    32'd1);
    chk("simul_pend",     32'(pending_o), 32'd0);
    wait_idle("simul_drain_timeout", 100);
    chk("simul_toggles", 32'(tog - base), 32'd2);

    // Reset while waiting for ack, far side stuck at 1
    pulse_i = 1'b1; tick(); pulse_i = 1'b0;
    chk("rst6_inflight", 32'(req_tgl_o), 32'd1);
    ack_manual = 1'b1; ack_val = 1'b1; rstB = 1'b1;
    tick(); rstB = 1'b0;
    chk("rst6_req",  32'(req_tgl_o), 32'd0);
    chk("rst6_pend", 32'(pending_o), 32'd0);
    repeat (2) tick();
    chk("rst6_busy", 32'(busy_o),    32'd1);
    pulse_i = 1'b1; repeat (3) tick(); pulse_i = 1'b0;
    chk("rst6_queued",  32'(pending_o), 32'd3);
    chk("rst6_no_launch", 32'(req_tgl_o), 32'd0);
    ack_val = 1'b0;
    repeat (2) tick();
    chk("rst6_req_e2",  32'(req_tgl_o), 32'd0);
    chk("rst6_pend_e2", 32'(pending_o), 32'd3);
    tick();
    chk("rst6_launch",  32'(req_tgl_o), 32'd1);
    chk("rst6_pend_e3", 32'(pending_o), 32'd2);
    chk("rst6_busy_e3", 32'(busy_o),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
